// File: rtl/adder_result_voter.sv
// Result voter and fault manager for the dual-channel self-checking adder.
// Optional macro ADDER_VOTER_ERRCNT_EN builds the saturating total-error counters.
module adder_result_voter #(
  parameter int WIDTH       = 3,
  parameter int CNT_W       = 8,
  parameter int FAIL_THRESH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x_sum,
  input  logic             x_carry,
  input  logic             x_e0,
  input  logic             x_e1,
  input  logic [WIDTH-1:0] y_sum,
  input  logic             y_carry,
  input  logic             y_e0,
  input  logic             y_e1,
  input  logic             clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic             out_src,
  output logic             out_err,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] x_err_cnt,
  output logic [CNT_W-1:0] y_err_cnt
);

  typedef enum logic [1:0] {
    DUAL   = 2'b00,
    X_ONLY = 2'b01,
    Y_ONLY = 2'b10,
    FAILED = 2'b11
  } state_e;

  localparam logic [3:0] THRESH = 4'(FAIL_THRESH);

  state_e           state_q, state_d;
  logic [3:0]       xfail_q, xfail_d, yfail_q, yfail_d;
  logic [3:0]       x_inc, y_inc;
  logic             x_retire, y_retire;
  logic             accept, xok, yok;
  logic             sel_y, sel_err;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_sum_q, out_sum_d;
  logic             out_carry_q, out_carry_d;
  logic             out_src_q, out_src_d;
  logic             out_err_q, out_err_d;

  assign xok      = x_e0 ^ x_e1;
  assign yok      = y_e0 ^ y_e1;
  assign in_ready = ~out_valid_q | out_ready;
  assign accept   = in_valid & in_ready;

  // Retirement is judged on the post-increment value, before any clr override.
  assign x_inc    = (xfail_q >= THRESH) ? THRESH : xfail_q + 4'd1;
  assign y_inc    = (yfail_q >= THRESH) ? THRESH : yfail_q + 4'd1;
  assign x_retire = accept & ~xok & (x_inc == THRESH);
  assign y_retire = accept & ~yok & (y_inc == THRESH);

  always_comb begin
    xfail_d = xfail_q;
    yfail_d = yfail_q;
    if (accept) begin
      xfail_d = xok ? '0 : x_inc;
      yfail_d = yok ? '0 : y_inc;
    end
    if (clr) begin
      xfail_d = '0;
      yfail_d = '0;
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DUAL;
      xfail_q <= '0;
      yfail_q <= '0;
    end else begin
      state_q <= state_d;
      xfail_q <= xfail_d;
      yfail_q <= yfail_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (accept) begin
      unique case (state_q)
        DUAL: begin
          if (x_retire && y_retire) state_d = FAILED;
          else if (x_retire)        state_d = Y_ONLY;
          else if (y_retire)        state_d = X_ONLY;
        end
        X_ONLY: if (x_retire) state_d = FAILED;
        Y_ONLY: if (y_retire) state_d = FAILED;
        FAILED: state_d = FAILED;
        default: state_d = FAILED;
      endcase
    end
    if (clr) state_d = DUAL;
  end

  // FSM: output (channel selection from the pre-accept state)
  always_comb begin
    sel_y   = 1'b0;
    sel_err = 1'b0;
    unique case (state_q)
      DUAL: begin
        if (xok && yok) begin
          sel_err = ({x_carry, x_sum} != {y_carry, y_sum});
        end else if (xok) begin
          sel_err = 1'b0;
        end else if (yok) begin
          sel_y = 1'b1;
        end else begin
          sel_err = 1'b1;
        end
      end
      X_ONLY: sel_err = ~xok;
      Y_ONLY: begin
        sel_y   = 1'b1;
        sel_err = ~yok;
      end
      FAILED: sel_err = 1'b1;
      default: sel_err = 1'b1;
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_carry_d = out_carry_q;
    out_src_d   = out_src_q;
    out_err_d   = out_err_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_sum_d   = sel_y ? y_sum : x_sum;
      out_carry_d = sel_y ? y_carry : x_carry;
      out_src_d   = sel_y;
      out_err_d   = sel_err;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_carry_q <= 1'b0;
      out_src_q   <= 1'b0;
      out_err_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_carry_q <= out_carry_d;
      out_src_q   <= out_src_d;
      out_err_q   <= out_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_carry = out_carry_q;
  assign out_src   = out_src_q;
  assign out_err   = out_err_q;
  assign state     = state_q;

`ifdef ADDER_VOTER_ERRCNT_EN
  logic [CNT_W-1:0] x_tot_q, x_tot_d, y_tot_q, y_tot_d;

  always_comb begin
    x_tot_d = x_tot_q;
    y_tot_d = y_tot_q;
    if (accept && !xok && (x_tot_q != '1)) x_tot_d = x_tot_q + CNT_W'(1);
    if (accept && !yok && (y_tot_q != '1)) y_tot_d = y_tot_q + CNT_W'(1);
    if (clr) begin
      x_tot_d = '0;
      y_tot_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_tot_q <= '0;
      y_tot_q <= '0;
    end else begin
      x_tot_q <= x_tot_d;
      y_tot_q <= y_tot_d;
    end
  end

  assign x_err_cnt = x_tot_q;
  assign y_err_cnt = y_tot_q;
`else
  assign x_err_cnt = '0;
  assign y_err_cnt = '0;
`endif

endmodule

// File: tb/tb_adder_result_voter.sv
// Self-checking bench for adder_result_voter: directed pins plus randomized traffic
// compared every cycle against a behavioural model.
module tb_adder_result_voter;
  localparam int W  = 3;
  localparam int CW = 8;
  localparam int T  = 4;
`ifdef ADDER_VOTER_ERRCNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready;
  logic [W-1:0]  x_sum, y_sum;
  logic          x_carry, x_e0, x_e1, y_carry, y_e0, y_e1;
  logic          clr, out_valid, out_ready;
  logic [W-1:0]  out_sum;
  logic          out_carry, out_src, out_err;
  logic [1:0]    state;
  logic [CW-1:0] x_err_cnt, y_err_cnt;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  always #5 clk = ~clk;

  adder_result_voter #(.WIDTH(W), .CNT_W(CW), .FAIL_THRESH(T)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x_sum(x_sum), .x_carry(x_carry), .x_e0(x_e0), .x_e1(x_e1),
    .y_sum(y_sum), .y_carry(y_carry), .y_e0(y_e0), .y_e1(y_e1),
    .clr(clr), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_carry(out_carry), .out_src(out_src), .out_err(out_err),
    .state(state), .x_err_cnt(x_err_cnt), .y_err_cnt(y_err_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: modes 0=both,1=X only,2=Y only,3=failed
  int m_state, cx, cy, tx, ty;
  bit m_valid;
  int m_sum, m_carry, m_src, m_err;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state = 0; cx = 0; cy = 0; tx = 0; ty = 0;
      m_valid = 0; m_sum = 0; m_carry = 0; m_src = 0; m_err = 0;
    end else begin : mdl
      bit acc, xo, yo, xr, yr;
      int ns;
      acc = in_valid && (!m_valid || out_ready);
      xo  = (x_e0 != x_e1);
      yo  = (y_e0 != y_e1);
      ns  = m_state;
      if (acc) begin
        bit take_y, e;
        take_y = 0; e = 0;
        case (m_state)
          0: if (xo && yo) e = (x_sum * 2 + x_carry) != (y_sum * 2 + y_carry);
             else if (xo) e = 0;
             else if (yo) take_y = 1;
             else e = 1;
          1: e = !xo;
          2: begin take_y = 1; e = !yo; end
          default: e = 1;
        endcase
        m_valid = 1;
        m_sum   = take_y ? y_sum : x_sum;
        m_carry = take_y ? y_carry : x_carry;
        m_src   = take_y;
        m_err   = e;
        cx = xo ? 0 : ((cx + 1 > T) ? T : cx + 1);
        cy = yo ? 0 : ((cy + 1 > T) ? T : cy + 1);
        xr = !xo && cx == T;
        yr = !yo && cy == T;
        if (m_state == 0 && xr && yr) ns = 3;
        else if (m_state == 0 && xr) ns = 2;
        else if (m_state == 0 && yr) ns = 1;
        else if (m_state == 1 && xr) ns = 3;
        else if (m_state == 2 && yr) ns = 3;
        if (!xo && tx < (1 << CW) - 1) tx++;
        if (!yo && ty < (1 << CW) - 1) ty++;
      end else if (out_ready) begin
        m_valid = 0;
      end
      m_state = ns;
      if (clr) begin
        m_state = 0; cx = 0; cy = 0; tx = 0; ty = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en && rst_n === 1'b1) begin
      check("in_ready",  in_ready,  !m_valid || out_ready);
      check("out_valid", out_valid, m_valid);
      check("out_sum",   out_sum,   m_sum);
      check("out_carry", out_carry, m_carry);
      check("out_src",   out_src,   m_src);
      check("out_err",   out_err,   m_err);
      check("state",     state,     m_state);
      check("x_err_cnt", x_err_cnt, CNT_ON ? tx : 0);
      check("y_err_cnt", y_err_cnt, CNT_ON ? ty : 0);
    end
  end

  task automatic put(input bit v, input logic [W-1:0] xs, input bit xc, input bit xa, input bit xb,
                     input logic [W-1:0] ys, input bit yc, input bit ya, input bit yb,
                     input bit rdy, input bit c);
    in_valid = v; x_sum = xs; x_carry = xc; x_e0 = xa; x_e1 = xb;
    y_sum = ys; y_carry = yc; y_e0 = ya; y_e1 = yb; out_ready = rdy; clr = c;
    @(posedge clk); #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_sum"},   out_sum,   0);
    check({tag, "_out_carry"}, out_carry, 0);
    check({tag, "_out_src"},   out_src,   0);
    check({tag, "_out_err"},   out_err,   0);
    check({tag, "_state"},     state,     0);
    check({tag, "_x_err_cnt"}, x_err_cnt, 0);
    check({tag, "_y_err_cnt"}, y_err_cnt, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 0; x_sum = '0; x_carry = 0; x_e0 = 0; x_e1 = 0;
    y_sum = '0; y_carry = 0; y_e0 = 0; y_e1 = 0; out_ready = 0; clr = 0;
    #12;
    check_reset_vals("rst");
    check("rst_in_ready", in_ready, 1);
    @(negedge clk); rst_n = 1'b1; cmp_en = 1'b1;
    @(posedge clk); #1;

    // Both ok and agreeing
    put(1, 3'b101, 0, 1, 0, 3'b101, 0, 0, 1, 1, 0);
    check("t1_valid", out_valid, 1); check("t1_sum", out_sum, 3'b101);
    check("t1_carry", out_carry, 0); check("t1_src", out_src, 0); check("t1_err", out_err, 0);

    // X code invalid, Y ok
    put(1, 3'b000, 0, 1, 1, 3'b010, 1, 0, 1, 1, 0);
    check("t2_sum", out_sum, 3'b010); check("t2_carry", out_carry, 1);
    check("t2_src", out_src, 1); check("t2_err", out_err, 0);
    check("t2_xcnt", x_err_cnt, CNT_ON ? 1 : 0);

    repeat (2) put(1, 3'b000, 0, 1, 1, 3'b010, 1, 0, 1, 1, 0);
    check("t3_state_at3", state, 2'b00);
    put(1, 3'b000, 0, 1, 1, 3'b010, 1, 0, 1, 1, 0);
    check("t3_state_at4", state, 2'b10);
    put(1, 3'b111, 0, 1, 0, 3'b001, 0, 0, 1, 1, 0);
    check("t3_sum", out_sum, 3'b001); check("t3_src", out_src, 1); check("t3_err", out_err, 0);

    // Backpressure stall
    for (int i = 0; i < 3; i++) begin
      put(1, 3'b011, 0, 1, 0, 3'b100, 0, 1, 0, 0, 0);
      check("stall_in_ready", in_ready, 0); check("stall_sum", out_sum, 3'b001);
      check("stall_valid", out_valid, 1); check("stall_xcnt", x_err_cnt, CNT_ON ? 4 : 0);
    end
    out_ready = 1; #1;
    check("unstall_in_ready", in_ready, 1);
    put(1, 3'b011, 0, 1, 0, 3'b100, 0, 1, 0, 1, 0);
    check("unstall_sum", out_sum, 3'b100); check("unstall_src", out_src, 1);

    // Retire Y as well
    for (int i = 0; i < 4; i++) begin
      put(1, 3'b110, 0, 1, 0, 3'b110, 0, 1, 1, 1, 0);
      check("yfail_err", out_err, 1);
      if (i == 2) check("yfail_state_at3", state, 2'b10);
    end
    check("failed_state", state, 2'b11);
    put(1, 3'b110, 1, 1, 0, 3'b001, 0, 0, 1, 1, 0);
    check("failed_err", out_err, 1); check("failed_src", out_src, 0);
    put(0, 3'b000, 0, 0, 0, 3'b000, 0, 0, 0, 1, 1);
    check("clr_state", state, 2'b00);
    check("clr_xcnt", x_err_cnt, 0); check("clr_ycnt", y_err_cnt, 0);

    // Randomized traffic
    begin
      int rate;
      rate = 10;
      for (int n = 0; n < 3000; n++) begin
        logic [W-1:0] xs, ys;
        bit xc, yc, xa, xb, ya, yb;
        if (n % 100 == 0) begin
          case ($urandom_range(0, 2))
            0: rate = 5;
            1: rate = 40;
            default: rate = 80;
          endcase
        end
        xs = W'($urandom_range(0, 7)); xc = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 9) < 7) begin ys = xs; yc = xc; end
        else begin ys = W'($urandom_range(0, 7)); yc = 1'($urandom_range(0, 1)); end
        xa = 1'($urandom_range(0, 1));
        xb = ($urandom_range(0, 99) < rate) ? xa : ~xa;
        ya = 1'($urandom_range(0, 1));
        yb = ($urandom_range(0, 99) < rate) ? ya : ~ya;
        put($urandom_range(0, 9) < 8, xs, xc, xa, xb, ys, yc, ya, yb,
            $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0);
      end
    end

    // Asynchronous reset with a result held
    put(1, 3'b101, 1, 1, 1, 3'b011, 1, 1, 1, 1, 0);
    in_valid = 0; out_ready = 0;
    check("pre_rst_valid", out_valid, 1);
    #2; rst_n = 1'b0; #1;
    check_reset_vals("async");
    @(negedge clk); rst_n = 1'b1;
    repeat (4) put(1, 3'b010, 0, 1, 0, 3'b010, 0, 1, 0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/adder_result_voter.md
# adder_result_voter

Registered result-selection and fault-management stage that sits directly downstream of the dual-channel (X/Y) self-checking 3-bit adder. It takes both channels' sum/carry and two-rail error codes, picks a trustworthy result, and presents it on a valid/ready output register. A state machine retires a channel after repeated code failures, and per-channel counters track error history.

## Interface
Parameters:
- WIDTH, 3: sum width of each adder channel.
- CNT_W, 8: width of the total-error counters.
- FAIL_THRESH, 4: consecutive invalid codes that retire a channel (1 to 15).

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream adder outputs are valid.
- in_ready  out  1  stage can accept this cycle.
- x_sum  in  WIDTH  X channel sum.
- x_carry  in  1  X channel carry.
- x_e0, x_e1  in  1 each  X two-rail code; valid when x_e0 != x_e1.
- y_sum  in  WIDTH  Y channel sum.
- y_carry  in  1  Y channel carry.
- y_e0, y_e1  in  1 each  Y two-rail code; valid when y_e0 != y_e1.
- clr  in  1  synchronous clear of state and counters.
- out_valid  out  1  output register holds a result.
- out_ready  in  1  downstream accepts.
- out_sum  out  WIDTH  selected sum.
- out_carry  out  1  selected carry.
- out_src  out  1  0 = X chosen, 1 = Y chosen.
- out_err  out  1  result is untrustworthy.
- state  out  2  fault state.
- x_err_cnt, y_err_cnt  out  CNT_W each  saturating total invalid-code counts.

## Operation
- Accept condition: in_valid & in_ready. in_ready = ~out_valid | out_ready (combinational). The stage is a single-entry buffer.
- Channel ok: xok = x_e0 ^ x_e1; yok = y_e0 ^ y_e1.
- Selection uses the state held before the accept:
  - DUAL (2'b00):
    - xok & yok, {carry,sum} equal: take X, err=0.
    - xok & yok, results differ: take X, err=1.
    - xok only: take X, err=0.
    - yok only: take Y, err=0.
    - Neither ok: take X, err=1.
  - X_ONLY (2'b01): always take X; err = ~xok. Y is ignored for selection.
  - Y_ONLY (2'b10): always take Y; err = ~yok.
  - FAILED (2'b11): take X; err=1.
- Consecutive-fail counters (4-bit, internal, one per channel):
  - An accept with the channel not ok increments the counter, saturating at FAIL_THRESH.
  - An accept with the channel ok zeroes it.
- State transitions, applied on the accept edge:
  - DUAL to Y_ONLY when the X counter reaches FAIL_THRESH.
  - DUAL to X_ONLY when the Y counter reaches FAIL_THRESH.
  - DUAL to FAILED when both reach FAIL_THRESH on the same accept.
  - X_ONLY to FAILED when the X counter reaches FAIL_THRESH.
  - Y_ONLY to FAILED when the Y counter reaches FAIL_THRESH.
  - No automatic recovery; leaving a degraded state requires clr or reset.
- Total counters: on every accept, x_err_cnt increments if ~xok and y_err_cnt increments if ~yok, regardless of state. Both saturate at 2^CNT_W-1.
- clr: state to DUAL; consecutive and total counters to 0. clr wins over any same-cycle counter or state update. A same-cycle accept still loads the output register, using the pre-clear state for selection.

## Timing
- Latency 1 cycle: an accept at edge N gives out_valid=1 with the result after edge N.
- out_* payload is stable while out_valid & ~out_ready.
- Back-to-back throughput is 1 per cycle when out_ready stays 1.
- When out_valid=0 the payload holds its last value, and downstream ignores it.
- Reset values: out_valid=0, out_sum=0, out_carry=0, out_src=0, out_err=0, state=2'b00, all counters 0. in_ready is 1 after reset.
- Reset asserted mid-transaction drops the buffered result immediately (asynchronously). No accept occurs while rst_n=0.

## Configuration
- ADDER_VOTER_ERRCNT_EN:
  - Defined: the total counters x_err_cnt and y_err_cnt are implemented as described.
  - Undefined: the counters are not built and both ports are tied to 0.
  - Selection, the consecutive counters and the state machine are identical in both builds.

## Test plan
- Both codes ok (x_e0=1, x_e1=0, y_e0=0, y_e1=1), X = Y = sum 3'b101, carry 0 -> next cycle out_valid=1, out_sum=101, out_carry=0, out_src=0, out_err=0.
- x_e0=x_e1=1, Y ok with sum 3'b010, carry 1 -> out_sum=010, out_carry=1, out_src=1, out_err=0, x_err_cnt=1 (macro on).
- Four consecutive accepts with X invalid and Y ok -> state=2'b10 after the 4th. Then X ok sum 3'b111 and Y ok sum 3'b001 -> out_sum=001, out_src=1, out_err=0.
- out_valid=1 held with out_ready=0 for 3 cycles while in_valid=1 -> in_ready=0, payload unchanged, no counter change. Then out_ready=1 -> next input accepted on that edge.
- Retire X, then four accepts with Y invalid -> state=2'b11, every result out_err=1. Then a one-cycle clr -> state=2'b00 and all counters 0.
- rst_n low mid-stream with out_valid=1 -> out_valid, out_sum, out_err, state and counters read 0 before the next clk edge.
